// File: rtl/alu_ctrl_decoder.sv
// RV32I decode stage: turns instruction words into ALU control, operand selects and immediate.
// Valid/ready on both sides, one-cycle latency, optional one-entry skid buffer.
module alu_ctrl_decoder #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FLUSH_i,
  input  logic            IN_VALID_i,
  output logic            IN_READY_o,
  input  logic [31:0]     INSTR_i,
  input  logic [XLEN-1:0] PC_i,
  output logic            OUT_VALID_o,
  input  logic            OUT_READY_i,
  output logic [3:0]      ALU_OP_o,
  output logic [1:0]      SRC_A_SEL_o,
  output logic            SRC_B_SEL_o,
  output logic [XLEN-1:0] IMM_o,
  output logic            IS_BRANCH_o,
  output logic            BR_INV_o,
  output logic            ILLEGAL_o,
  output logic [XLEN-1:0] PC_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SUM  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_GE   = 4'b1100;
  localparam logic [3:0] OP_GEU  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  localparam logic [1:0] SEL_RS1  = 2'b00;
  localparam logic [1:0] SEL_PC   = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [3:0]      op;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic [XLEN-1:0] imm;
    logic            is_branch;
    logic            br_inv;
    logic            illegal;
  } dec_t;

  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_SUM;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = INSTR_i[6:0];
  assign f3     = INSTR_i[14:12];
  assign f7     = INSTR_i[31:25];
  assign imm_i  = {{20{INSTR_i[31]}}, INSTR_i[31:20]};
  assign imm_s  = {{20{INSTR_i[31]}}, INSTR_i[31:25], INSTR_i[11:7]};
  assign imm_b  = {{20{INSTR_i[31]}}, INSTR_i[7], INSTR_i[30:25], INSTR_i[11:8], 1'b0};
  assign imm_u  = {INSTR_i[31:12], 12'b0};
  assign imm_j  = {{12{INSTR_i[31]}}, INSTR_i[19:12], INSTR_i[20], INSTR_i[30:21], 1'b0};
  assign imm_sh = {27'b0, INSTR_i[24:20]};

  dec_t dec;
  logic legal;

  // Any encoding found unsupported collapses to the same canonical illegal entry.
  always_comb begin
    dec      = '0;
    dec.op   = OP_SUM;
    legal    = 1'b1;
    case (opcode)
      7'b0110011: begin
        if (f7 == 7'b0)                      dec.op = f3_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) dec.op = OP_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) dec.op = OP_SRA;
        else                                 legal = 1'b0;
      end
      7'b0010011: begin
        dec.op    = f3_op(f3);
        dec.b_sel = 1'b1;
        dec.imm   = sext(imm_i);
        if (f3 == 3'b001) begin
          dec.imm = sext(imm_sh);
          if (f7 != 7'b0) legal = 1'b0;
        end else if (f3 == 3'b101) begin
          dec.imm = sext(imm_sh);
          if (f7 == F7_ALT)     dec.op = OP_SRA;
          else if (f7 != 7'b0)  legal  = 1'b0;
        end
      end
      7'b1100011: begin
        dec.is_branch = 1'b1;
        dec.imm       = sext(imm_b);
        dec.br_inv    = 1'b1;
        case (f3)
          3'b000: begin dec.op = OP_SUB; dec.br_inv = 1'b0; end
          3'b001: dec.op = OP_SUB;
          3'b100: dec.op = OP_SLT;
          3'b101: dec.op = OP_GE;
          3'b110: dec.op = OP_SLTU;
          3'b111: dec.op = OP_GEU;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011, 7'b1100111: begin
        dec.b_sel = 1'b1;
        dec.imm   = sext(imm_i);
      end
      7'b0100011: begin
        dec.b_sel = 1'b1;
        dec.imm   = sext(imm_s);
      end
      7'b1101111: begin
        dec.a_sel = SEL_PC;
        dec.b_sel = 1'b1;
        dec.imm   = sext(imm_j);
      end
      7'b0010111: begin
        dec.a_sel = SEL_PC;
        dec.b_sel = 1'b1;
        dec.imm   = sext(imm_u);
      end
      7'b0110111: begin
        dec.a_sel = SEL_ZERO;
        dec.b_sel = 1'b1;
        dec.imm   = sext(imm_u);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.op      = OP_SUM;
      dec.illegal = 1'b1;
    end
  end

  // Handshake: a word transfers on any edge where valid & ready are both high;
  // valid never waits on ready, and a held output stays stable until consumed.
  dec_t            out_d, skid_d;
  logic [XLEN-1:0] out_pc, skid_pc;
  logic            out_valid, skid_valid;
  logic            accept;

  assign IN_READY_o = (SKID != 0) ? ~skid_valid : (OUT_READY_i | ~out_valid);
  assign accept     = IN_VALID_i & IN_READY_o;

  always_ff @(posedge clk) begin
    if (rst || FLUSH_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_d      <= '0;
      skid_d     <= '0;
      out_pc     <= '0;
      skid_pc    <= '0;
    end else if (out_valid && !OUT_READY_i) begin
      if (accept) begin
        skid_valid <= 1'b1;
        skid_d     <= dec;
        skid_pc    <= PC_i;
      end
    end else if (skid_valid) begin
      out_valid  <= 1'b1;
      out_d      <= skid_d;
      out_pc     <= skid_pc;
      skid_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_d  <= dec;
        out_pc <= PC_i;
      end
    end
  end

  assign OUT_VALID_o = out_valid;
  assign ALU_OP_o    = out_d.op;
  assign SRC_A_SEL_o = out_d.a_sel;
  assign SRC_B_SEL_o = out_d.b_sel;
  assign IMM_o       = out_d.imm;
  assign IS_BRANCH_o = out_d.is_branch;
  assign BR_INV_o    = out_d.br_inv;
  assign ILLEGAL_o   = out_d.illegal;
  assign PC_o        = out_pc;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed bench for alu_ctrl_decoder: decode table, skid backpressure ordering, flush.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_alu_ctrl_decoder;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] pc_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [3:0]      alu_op;
  logic [1:0]      src_a_sel;
  logic            src_b_sel;
  logic [XLEN-1:0] imm;
  logic            is_branch;
  logic            br_inv;
  logic            illegal;
  logic [XLEN-1:0] pc_out;

  alu_ctrl_decoder #(.XLEN(XLEN), .SKID(1)) dut (
    .clk(clk), .rst(rst), .FLUSH_i(flush),
    .IN_VALID_i(in_valid), .IN_READY_o(in_ready),
    .INSTR_i(instr), .PC_i(pc_in),
    .OUT_VALID_o(out_valid), .OUT_READY_i(out_ready),
    .ALU_OP_o(alu_op), .SRC_A_SEL_o(src_a_sel), .SRC_B_SEL_o(src_b_sel),
    .IMM_o(imm), .IS_BRANCH_o(is_branch), .BR_INV_o(br_inv),
    .ILLEGAL_o(illegal), .PC_o(pc_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [XLEN-1:0] p);
    in_valid = 1'b1;
    instr    = w;
    pc_in    = p;
  endtask

  typedef struct {
    logic [31:0]     instr;
    logic [3:0]      op;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic [XLEN-1:0] imm;
    logic            br;
    logic            inv;
    logic            ill;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{32'h003100B3, 4'b0010, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0}; // add
    vecs[1]  = '{32'h403100B3, 4'b1010, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0}; // sub
    vecs[2]  = '{32'h40315093, 4'b0111, 2'b00, 1'b1, 32'h3,        1'b0, 1'b0, 1'b0}; // srai
    vecs[3]  = '{32'h00317463, 4'b1101, 2'b00, 1'b0, 32'h8,        1'b1, 1'b1, 1'b0}; // bgeu
    vecs[4]  = '{32'h00208463, 4'b1010, 2'b00, 1'b0, 32'h8,        1'b1, 1'b0, 1'b0}; // beq
    vecs[5]  = '{32'h02000033, 4'b0010, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1}; // mul
    vecs[6]  = '{32'h0000007F, 4'b0010, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1}; // bad opcode
    vecs[7]  = '{32'h12345037, 4'b0010, 2'b10, 1'b1, 32'h12345000, 1'b0, 1'b0, 1'b0}; // lui
    vecs[8]  = '{32'h008000EF, 4'b0010, 2'b01, 1'b1, 32'h8,        1'b0, 1'b0, 1'b0}; // jal +8
    vecs[9]  = '{32'hFFC12083, 4'b0010, 2'b00, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0}; // lw -4
    vecs[10] = '{32'h40311093, 4'b0010, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1}; // slli bad f7
    vecs[11] = '{32'h00000010, 4'b0010, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1}; // instr[1:0]=00
    vecs[12] = '{32'h00314093, 4'b1000, 2'b00, 1'b1, 32'h3,        1'b0, 1'b0, 1'b0}; // xori 3
  end

  initial begin
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_op", alu_op, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].instr, XLEN'(32'h1000 + 4 * i));
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_op", i), alu_op, vecs[i].op);
      check($sformatf("v%0d_asel", i), src_a_sel, vecs[i].a_sel);
      check($sformatf("v%0d_bsel", i), src_b_sel, vecs[i].b_sel);
      check($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      check($sformatf("v%0d_br", i), {is_branch, br_inv}, {vecs[i].br, vecs[i].inv});
      check($sformatf("v%0d_ill", i), illegal, vecs[i].ill);
      check($sformatf("v%0d_pc", i), pc_out, 32'h1000 + 4 * i);
    end
    step();
    check("idle_valid", out_valid, 0);

    // Backpressure: A held, B into skid, C stalled at the input.
    out_ready = 1'b0;
    drive(32'h003100B3, 32'hA0); exp_q.push_back(32'hA0);
    step();
    drive(32'h403100B3, 32'hB0); exp_q.push_back(32'hB0);
    step();
    check("skid_in_ready", in_ready, 0);
    drive(32'h00314093, 32'hC0); exp_q.push_back(32'hC0);
    step();
    check("hold_pc", pc_out, 32'hA0);
    check("hold_op", alu_op, 4'b0010);
    check("hold_ready", in_ready, 0);
    step();
    check("hold2_pc", pc_out, 32'hA0);
    check("hold2_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain%0d_valid", k), out_valid, 1);
      check($sformatf("drain%0d_pc", k), pc_out, exp_q.pop_front());
      step();
      if (k == 1) in_valid = 1'b0;
    end
    check("drain_op_c", 0, 0 + (out_valid ? 1 : 0));

    // Flush with skid full and a valid word offered.
    out_ready = 1'b0;
    drive(32'h003100B3, 32'hD0);
    step();
    drive(32'h403100B3, 32'hE0);
    step();
    check("pre_flush_ready", in_ready, 0);
    drive(32'h00314093, 32'hF0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    check("flush_op", alu_op, 4'b0000);
    check("flush_pc", pc_out, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_flush%0d_valid", k), out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
